// File: rtl/serial_subtractor_nb.sv
// Bit-serial n-bit subtractor: Diff = a - b - Bin, one bit per clock, LSB first.
// One full-subtractor cell plus a borrow flip-flop; start/busy/done handshake.
// Result and N/Z/V/Bout flags are registered and only change on entry to DONE.
module serial_subtractor_nb #(
    parameter int n = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic         Bin,
    output logic         busy,
    output logic         done,
    output logic [n-1:0] Diff,
    output logic         Bout,
    output logic         N,
    output logic         Z,
    output logic         V
);

    localparam int CW = $clog2(n);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic [n-1:0]    r_a_sh;
    logic [n-1:0]    r_b_sh;
    logic [n-1:0]    r_res;
    logic [CW-1:0]   r_cnt;
    logic            r_brw;
    logic            r_a_msb;
    logic            r_b_msb;

    logic            w_x;
    logic            w_y;
    logic            w_d;
    logic            w_brw_nxt;
    logic [n-1:0]    w_res_nxt;

    // Full-subtractor cell on the current LSBs and the stored borrow
    always_comb begin
        w_x       = r_a_sh[0];
        w_y       = r_b_sh[0];
        w_d       = w_x ^ w_y ^ r_brw;
        w_brw_nxt = (~w_x & w_y) | (~(w_x ^ w_y) & r_brw);
        w_res_nxt = {w_d, r_res[n-1:1]};
    end

    // Control FSM with datapath shifts and registered outputs.
    // The final bit is folded into the outputs on the edge that enters DONE,
    // so results are valid in the same cycle that done is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_res   <= '0;
            r_cnt   <= '0;
            r_brw   <= 1'b0;
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            Diff    <= '0;
            Bout    <= 1'b0;
            N       <= 1'b0;
            Z       <= 1'b0;
            V       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_a_sh  <= a;
                        r_b_sh  <= b;
                        r_brw   <= Bin;
                        r_a_msb <= a[n-1];
                        r_b_msb <= b[n-1];
                        r_res   <= '0;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_a_sh <= r_a_sh >> 1;
                    r_b_sh <= r_b_sh >> 1;
                    r_res  <= w_res_nxt;
                    r_brw  <= w_brw_nxt;
                    r_cnt  <= r_cnt + CW'(1);
                    if (r_cnt == CW'(n - 1)) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        Diff    <= w_res_nxt;
                        Bout    <= w_brw_nxt;
                        N       <= w_d;
                        Z       <= (w_res_nxt == '0);
                        V       <= (r_a_msb ^ r_b_msb) & (w_d ^ r_a_msb);
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor_nb.sv
// Bench for serial_subtractor_nb: n=4 and n=8 instances checked against an
// integer-arithmetic reference model, plus handshake and reset scenarios.
module tb_serial_subtractor_nb;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // n=4 instance
    logic       st4 = 1'b0, bin4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       busy4, done4, bout4, n4, z4, v4;
    logic [3:0] diff4;

    // n=8 instance
    logic       st8 = 1'b0, bin8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, bout8, n8, z8, v8;
    logic [7:0] diff8;

    int vec = 0;
    int err = 0;

    serial_subtractor_nb #(.n(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(st4), .a(a4), .b(b4), .Bin(bin4),
        .busy(busy4), .done(done4), .Diff(diff4), .Bout(bout4),
        .N(n4), .Z(z4), .V(v4)
    );

    serial_subtractor_nb #(.n(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(st8), .a(a8), .b(b8), .Bin(bin8),
        .busy(busy8), .done(done8), .Diff(diff8), .Bout(bout8),
        .N(n8), .Z(z8), .V(v8)
    );

    // Reference: plain integer arithmetic; flags packed as {Diff,Bout,N,Z,V}
    function automatic logic [12:0] model(input int w, input int av, input int bv, input int bi);
        int full, d, sa, sb, sr, half;
        logic bo, nn, zz, vv;
        half = 1 << (w - 1);
        full = av - bv - bi;
        d    = full & ((1 << w) - 1);
        bo   = (full < 0);
        nn   = ((d >> (w - 1)) & 1) != 0;
        zz   = (d == 0);
        sa   = (av >= half) ? av - (1 << w) : av;
        sb   = (bv >= half) ? bv - (1 << w) : bv;
        sr   = sa - sb - bi;
        vv   = (sr < -half) || (sr > half - 1);
        return {d[8:0], bo, nn, zz, vv};
    endfunction

    // Drive one n=4 operation; report latency (cycles counted from the
    // accepting edge), busy cycles and any busy&done overlap.
    task automatic op4(input logic [3:0] av, input logic [3:0] bv, input logic bi,
                       output int lat, output int bcyc, output int ovl);
        @(negedge clk);
        a4 = av; b4 = bv; bin4 = bi; st4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        st4 = 1'b0;
        lat = 1; bcyc = 0; ovl = 0;
        while (!done4 && lat < 30) begin
            if (busy4) bcyc++;
            @(negedge clk);
            lat++;
        end
        if (busy4 && done4) ovl = 1;
        @(negedge clk);
    endtask

    task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic bi,
                       output int lat);
        @(negedge clk);
        a8 = av; b8 = bv; bin8 = bi; st8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        st8 = 1'b0;
        lat = 1;
        while (!done8 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        vec++;
        if ({busy4, done4, diff4, bout4, n4, z4, v4} !== 10'b0) begin
            err++;
            $display("FAIL reset4: got %b want 0", {busy4, done4, diff4, bout4, n4, z4, v4});
        end
        vec++;
        if ({busy8, done8, diff8, bout8, n8, z8, v8} !== 14'b0) begin
            err++;
            $display("FAIL reset8: got %b want 0", {busy8, done8, diff8, bout8, n8, z8, v8});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int lat, bcyc, ovl;
        op4(4'd7, 4'd3, 1'b0, lat, bcyc, ovl);
        vec++;
        if (lat !== 5) begin err++; $display("FAIL basic_latency: got %0d want 5", lat); end
        vec++;
        if (bcyc !== 4) begin err++; $display("FAIL basic_busy_cycles: got %0d want 4", bcyc); end
        vec++;
        if (ovl !== 0) begin err++; $display("FAIL basic_busy_done_overlap: got %0d want 0", ovl); end
        vec++;
        if ({diff4, bout4, n4, z4, v4} !== {4'd4, 4'b0000}) begin
            err++;
            $display("FAIL basic_result: got %h/%b want 4/0000", diff4, {bout4, n4, z4, v4});
        end
    endtask

    // Spec corner table followed by random n=4 operands
    task automatic test_flags4();
        logic [3:0] ta[6] = '{4'd3, 4'd5, 4'd0, 4'd8, 4'd7, 4'd0};
        logic [3:0] tb_[6] = '{4'd7, 4'd5, 4'd0, 4'd1, 4'hF, 4'hF};
        logic       tbi[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [12:0] e;
        logic [3:0] av, bv;
        logic bi;
        int lat, bcyc, ovl;
        for (int i = 0; i < 26; i++) begin
            if (i < 6) begin
                av = ta[i]; bv = tb_[i]; bi = tbi[i];
            end else begin
                av = 4'($urandom); bv = 4'($urandom); bi = 1'($urandom);
            end
            e = model(4, int'(av), int'(bv), int'(bi));
            op4(av, bv, bi, lat, bcyc, ovl);
            vec++;
            if ({diff4, bout4, n4, z4, v4} !== {e[7:4], e[3:0]}) begin
                err++;
                $display("FAIL flags4 a=%h b=%h bin=%b: got %h/%b want %h/%b",
                         av, bv, bi, diff4, {bout4, n4, z4, v4}, e[7:4], e[3:0]);
            end
            vec++;
            if (lat !== 5 || ovl !== 0) begin
                err++;
                $display("FAIL flags4_timing a=%h b=%h: got lat=%0d ovl=%0d want 5/0", av, bv, lat, ovl);
            end
        end
    endtask

    // Start pulse and operand changes during RUN are ignored; outputs hold
    task automatic test_handshake();
        int lat;
        logic held_ok;
        @(negedge clk);
        a4 = 4'd12; b4 = 4'd5; bin4 = 1'b0; st4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        st4 = 1'b0;
        @(negedge clk);
        a4 = 4'd1; b4 = 4'd1; bin4 = 1'b1; st4 = 1'b1;
        @(negedge clk);
        st4 = 1'b0;
        lat = 3;
        while (!done4 && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        vec++;
        if (lat !== 5) begin err++; $display("FAIL ignore_start_latency: got %0d want 5", lat); end
        vec++;
        if ({diff4, bout4} !== {4'd7, 1'b0}) begin
            err++;
            $display("FAIL ignore_operand_change: got %h/%b want 7/0", diff4, bout4);
        end
        held_ok = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (diff4 !== 4'd7 || done4 !== 1'b0 || busy4 !== 1'b0) held_ok = 1'b0;
        end
        vec++;
        if (held_ok !== 1'b1) begin err++; $display("FAIL hold_idle: got diff=%h want 7", diff4); end
        // New operation: old result must persist through RUN
        a4 = 4'd2; b4 = 4'd1; bin4 = 1'b0; st4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        st4 = 1'b0;
        held_ok = 1'b1;
        lat = 1;
        while (!done4 && lat < 30) begin
            if (diff4 !== 4'd7) held_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        vec++;
        if (held_ok !== 1'b1) begin err++; $display("FAIL hold_run: got diff changed before done want 7"); end
        vec++;
        if (diff4 !== 4'd1) begin err++; $display("FAIL second_result: got %h want 1", diff4); end
        @(negedge clk);
    endtask

    // start held high: done pulses every n+2 = 6 cycles
    task automatic test_back_to_back();
        int cyc, ndone, last;
        int gaps[$];
        @(negedge clk);
        a4 = 4'd10; b4 = 4'd3; bin4 = 1'b0; st4 = 1'b1;
        cyc = 0; ndone = 0; last = 0;
        while (ndone < 3 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (done4) begin
                if (ndone > 0) gaps.push_back(cyc - last);
                last = cyc;
                ndone++;
            end
        end
        st4 = 1'b0;
        @(negedge clk);
        vec++;
        if (ndone !== 3) begin err++; $display("FAIL b2b_count: got %0d want 3", ndone); end
        foreach (gaps[i]) begin
            vec++;
            if (gaps[i] !== 6) begin err++; $display("FAIL b2b_gap%0d: got %0d want 6", i, gaps[i]); end
        end
        vec++;
        if (diff4 !== 4'd7) begin err++; $display("FAIL b2b_result: got %h want 7", diff4); end
    endtask

    task automatic test_reset_mid();
        int lat, bcyc, ovl;
        logic saw_done;
        @(negedge clk);
        a4 = 4'd6; b4 = 4'd1; bin4 = 1'b0; st4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        st4 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        vec++;
        if ({busy4, done4, diff4, bout4, n4, z4, v4} !== 10'b0) begin
            err++;
            $display("FAIL mid_reset_outputs: got %b want 0", {busy4, done4, diff4, bout4, n4, z4, v4});
        end
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (done4 || busy4) saw_done = 1'b1;
        end
        vec++;
        if (saw_done !== 1'b0) begin err++; $display("FAIL mid_reset_no_done: got activity want none"); end
        op4(4'd9, 4'd2, 1'b0, lat, bcyc, ovl);
        vec++;
        if ({diff4, bout4} !== {4'd7, 1'b0} || lat !== 5) begin
            err++;
            $display("FAIL after_reset_op: got %h/%b lat=%0d want 7/0 lat=5", diff4, bout4, lat);
        end
    endtask

    task automatic test_width_sweep();
        logic [7:0] corners[4] = '{8'h00, 8'hFF, 8'h80, 8'h7F};
        logic [7:0] av, bv;
        logic bi;
        logic [12:0] e;
        int lat;
        for (int i = 0; i < 36; i++) begin
            if (i < 16) begin
                av = corners[i / 4]; bv = corners[i % 4]; bi = 1'($urandom);
            end else begin
                av = 8'($urandom); bv = 8'($urandom); bi = 1'($urandom);
            end
            e = model(8, int'(av), int'(bv), int'(bi));
            op8(av, bv, bi, lat);
            vec++;
            if ({diff8, bout8, n8, z8, v8} !== {e[11:4], e[3:0]}) begin
                err++;
                $display("FAIL sweep8 a=%h b=%h bin=%b: got %h/%b want %h/%b",
                         av, bv, bi, diff8, {bout8, n8, z8, v8}, e[11:4], e[3:0]);
            end
            vec++;
            if (lat !== 9) begin err++; $display("FAIL sweep8_latency a=%h b=%h: got %0d want 9", av, bv, lat); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_flags4();
        test_handshake();
        test_back_to_back();
        test_reset_mid();
        test_width_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
